// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared state encoding, error codes and geometry for the slot programmer
package flash_pkg;

  localparam int unsigned PAGE_BITS  = 2048;
  localparam int unsigned SLOT_PAGES = 8192;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_VERIFY   = 2'd1;
  localparam logic [1:0] ERR_ERASE_TO = 2'd2;
  localparam logic [1:0] ERR_WRITE_TO = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_ERASE_WAIT,
    ST_PAGE_WAIT,
    ST_WRITE_WAIT,
    ST_VERIFY,
    ST_FINISH,
    ST_FAIL
  } fsm_state_t;

endpackage

// File: rtl/toggle_sync_ack.sv
// rtl/toggle_sync_ack.sv - toggle request register plus seen register that turns a done toggle into a pulse
module toggle_sync_ack (
  input  logic clock,
  input  logic fire,
  input  logic track,
  input  logic arm,
  input  logic done_tgl,
  output logic req,
  output logic ack_pulse
);

  // No reset: the flash side has none, so a reset here would fake a toggle.
  logic req_q  = 1'b0;
  logic seen_q = 1'b0;

  assign req       = req_q;
  assign ack_pulse = arm && (done_tgl != seen_q);

  always_ff @(posedge clock) begin
    if (fire) req_q <= ~req_q;
    if (track || ack_pulse) seen_q <= done_tgl;
  end

endmodule

// File: rtl/flash_slot_programmer.sv
// rtl/flash_slot_programmer.sv - erases one slot, then writes and read-back verifies each incoming page
module flash_slot_programmer
  import flash_pkg::*;
#(
  parameter int unsigned PAGES_PER_SLOT = SLOT_PAGES,
  parameter logic [31:0] ERASE_TIMEOUT  = 32'd1_500_000_000,
  parameter logic [31:0] WRITE_TIMEOUT  = 32'd2_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           slot_sel,
  input  logic                 page_valid,
  input  logic [PAGE_BITS-1:0] page_in,
  output logic                 page_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [13:0]          page_count,
  output logic [1:0]           fl_slot_num,
  output logic                 fl_erase_req,
  output logic                 fl_write_req,
  output logic [PAGE_BITS-1:0] fl_wr_data,
  input  logic                 fl_erase_done,
  input  logic                 fl_wr_done,
  input  logic [PAGE_BITS-1:0] fl_rd_data
);

  localparam logic [13:0] LAST_PAGE = 14'(PAGES_PER_SLOT - 1);

  fsm_state_t  state, state_d;
  logic [31:0] timer;
  logic [31:0] timer_limit;
  logic [1:0]  fail_code, fail_code_d;
  logic        abort_pend;
  logic        erase_go, write_go, cnt_inc;
  logic        erase_ack, write_ack;
  logic        in_wait;

  toggle_sync_ack u_erase_hs (
    .clock     (clock),
    .fire      (erase_go),
    .track     (state == ST_IDLE),
    .arm       (state == ST_ERASE_WAIT),
    .done_tgl  (fl_erase_done),
    .req       (fl_erase_req),
    .ack_pulse (erase_ack)
  );

  toggle_sync_ack u_write_hs (
    .clock     (clock),
    .fire      (write_go),
    .track     (state == ST_IDLE),
    .arm       (state == ST_WRITE_WAIT),
    .done_tgl  (fl_wr_done),
    .req       (fl_write_req),
    .ack_pulse (write_ack)
  );

  assign page_ready  = (state == ST_PAGE_WAIT);
  assign done        = (state == ST_FINISH);
  assign in_wait     = (state == ST_ERASE_WAIT) || (state == ST_WRITE_WAIT);
  assign timer_limit = (state == ST_ERASE_WAIT) ? ERASE_TIMEOUT : WRITE_TIMEOUT;

  always_comb begin
    state_d     = state;
    fail_code_d = fail_code;
    erase_go    = 1'b0;
    write_go    = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      ST_IDLE: if (start) state_d = ST_ERASE;
      ST_ERASE: begin
        erase_go = 1'b1;
        state_d  = ST_ERASE_WAIT;
      end
      ST_ERASE_WAIT: begin
        if (erase_ack) begin
          state_d     = abort_pend ? ST_FAIL : ST_PAGE_WAIT;
          fail_code_d = ERR_NONE;
        end else if (timer == ERASE_TIMEOUT) begin
          state_d     = ST_FAIL;
          fail_code_d = ERR_ERASE_TO;
        end
      end
      ST_PAGE_WAIT: begin
        if (abort || abort_pend) begin
          state_d     = ST_FAIL;
          fail_code_d = ERR_NONE;
        end else if (page_valid) begin
          write_go = 1'b1;
          state_d  = ST_WRITE_WAIT;
        end
      end
      ST_WRITE_WAIT: begin
        // An abort only lands once the flash transaction has finished.
        if (write_ack) begin
          state_d     = abort_pend ? ST_FAIL : ST_VERIFY;
          fail_code_d = ERR_NONE;
        end else if (timer == WRITE_TIMEOUT) begin
          state_d     = ST_FAIL;
          fail_code_d = ERR_WRITE_TO;
        end
      end
      ST_VERIFY: begin
        if (fl_rd_data != fl_wr_data) begin
          state_d     = ST_FAIL;
          fail_code_d = ERR_VERIFY;
        end else begin
          cnt_inc = 1'b1;
          state_d = (page_count == LAST_PAGE) ? ST_FINISH : ST_PAGE_WAIT;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_FAIL:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      fail_code   <= ERR_NONE;
      abort_pend  <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
      err_code    <= ERR_NONE;
      page_count  <= '0;
      fl_slot_num <= '0;
      fl_wr_data  <= '0;
    end else begin
      state     <= state_d;
      fail_code <= fail_code_d;

      if (erase_go || write_go) timer <= '0;
      else if (in_wait && timer != timer_limit) timer <= timer + 32'd1;

      if (state == ST_IDLE && start) begin
        fl_slot_num <= slot_sel;
        error       <= 1'b0;
        err_code    <= ERR_NONE;
        page_count  <= '0;
        busy        <= 1'b1;
        abort_pend  <= 1'b0;
      end else if (abort && busy && state != ST_PAGE_WAIT) begin
        abort_pend <= 1'b1;
      end

      if (write_go) fl_wr_data <= page_in;
      if (cnt_inc) page_count <= page_count + 14'd1;
      if (state == ST_FINISH) busy <= 1'b0;
      if (state == ST_FAIL) begin
        error    <= 1'b1;
        err_code <= fail_code;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flash_slot_programmer.sv
// tb/tb_flash_slot_programmer.sv - scoreboard bench with a behavioural toggle-handshake flash model
module tb_flash_slot_programmer;
  import flash_pkg::*;

  localparam int NP = 4;
  localparam int ERASE_DLY = 8;
  localparam int WRITE_DLY = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic [1:0]           slot_sel = 2'd0;
  logic                 page_valid = 1'b0;
  logic [PAGE_BITS-1:0] page_in = '0;
  logic                 page_ready, busy, done, error;
  logic [1:0]           err_code;
  logic [13:0]          page_count;
  logic [1:0]           fl_slot_num;
  logic                 fl_erase_req, fl_write_req;
  logic [PAGE_BITS-1:0] fl_wr_data;
  logic                 fl_erase_done = 1'b0;
  logic                 fl_wr_done = 1'b0;
  logic [PAGE_BITS-1:0] fl_rd_data = '0;

  flash_slot_programmer #(
    .PAGES_PER_SLOT (NP),
    .ERASE_TIMEOUT  (32'd100),
    .WRITE_TIMEOUT  (32'd300)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .slot_sel      (slot_sel),
    .page_valid    (page_valid),
    .page_in       (page_in),
    .page_ready    (page_ready),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code),
    .page_count    (page_count),
    .fl_slot_num   (fl_slot_num),
    .fl_erase_req  (fl_erase_req),
    .fl_write_req  (fl_write_req),
    .fl_wr_data    (fl_wr_data),
    .fl_erase_done (fl_erase_done),
    .fl_wr_done    (fl_wr_done),
    .fl_rd_data    (fl_rd_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [PAGE_BITS-1:0] exp_q[$];
  logic [PAGE_BITS-1:0] exp_page;
  logic prev_e = 1'b0, prev_w = 1'b0;
  int   e_cnt = -1, w_cnt = -1, widx = 0;
  int   n_erase = 0, n_wr = 0, n_done = 0, e_tog_cyc = 0;
  int   corrupt_idx = -1;
  bit   erase_hang = 1'b0, w_hold = 1'b0;

  // Flash model: reacts on the falling edge, echoes written data unless told to corrupt a page.
  always @(negedge clock) begin
    if (done) n_done++;
    if (fl_erase_req != prev_e) begin
      prev_e = fl_erase_req;
      n_erase++;
      e_tog_cyc = cyc;
      widx = 0;
      e_cnt = erase_hang ? -1 : ERASE_DLY;
    end else if (e_cnt > 0) begin
      e_cnt--;
    end else if (e_cnt == 0) begin
      fl_erase_done = ~fl_erase_done;
      e_cnt = -1;
    end
    if (fl_write_req != prev_w) begin
      prev_w = fl_write_req;
      n_wr++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", 64'd1, 64'd0);
      end else begin
        exp_page = exp_q.pop_front();
        check("sb_wr_page", 64'(fl_wr_data == exp_page), 64'd1);
      end
      w_cnt = WRITE_DLY;
    end else if (w_cnt > 0) begin
      w_cnt--;
    end else if (w_cnt == 0 && !w_hold) begin
      fl_rd_data = fl_wr_data;
      if (widx == corrupt_idx) fl_rd_data[0] = ~fl_rd_data[0];
      fl_wr_done = ~fl_wr_done;
      widx++;
      w_cnt = -1;
    end
  end

  function automatic logic [PAGE_BITS-1:0] rand_page();
    logic [PAGE_BITS-1:0] p;
    for (int k = 0; k < PAGE_BITS / 32; k++) p[k*32 +: 32] = $urandom();
    return p;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start(input logic [1:0] s);
    slot_sel = s;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_page(input logic [PAGE_BITS-1:0] d);
    int t = 0;
    while (!page_ready && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (!page_ready) begin
      check("page_ready_timeout", 64'd0, 64'd1);
      return;
    end
    page_in = d;
    page_valid = 1'b1;
    exp_q.push_back(d);
    @(negedge clock);
    page_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 3000) begin
      @(negedge clock);
      t++;
    end
    check("busy_timeout", 64'(busy), 64'd0);
  endtask

  int e0, w0, d0, t;
  logic [PAGE_BITS-1:0] held;

  initial begin
    tick(3);
    check("rst_page_ready", 64'(page_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_page_count", 64'(page_count), 64'd0);
    check("rst_slot", 64'(fl_slot_num), 64'd0);
    check("rst_wr_data", fl_wr_data[63:0], 64'd0);
    reset = 1'b0;
    tick(2);

    // Full slot of NP pages into slot 2
    e0 = n_erase; w0 = n_wr; d0 = n_done;
    pulse_start(2'd2);
    check("t1_busy", 64'(busy), 64'd1);
    for (int i = 0; i < NP; i++) send_page(rand_page());
    wait_idle();
    tick(10);
    check("t1_slot", 64'(fl_slot_num), 64'd2);
    check("t1_erases", 64'(n_erase - e0), 64'd1);
    check("t1_writes", 64'(n_wr - w0), 64'(NP));
    check("t1_page_count", 64'(page_count), 64'(NP));
    check("t1_done_pulses", 64'(n_done - d0), 64'd1);
    check("t1_error", 64'(error), 64'd0);

    // Read-back of the second page corrupted
    corrupt_idx = 1;
    w0 = n_wr; d0 = n_done;
    pulse_start(2'd1);
    send_page(rand_page());
    send_page(rand_page());
    wait_idle();
    tick(30);
    corrupt_idx = -1;
    check("t2_error", 64'(error), 64'd1);
    check("t2_err_code", 64'(err_code), 64'(ERR_VERIFY));
    check("t2_page_count", 64'(page_count), 64'd1);
    check("t2_busy", 64'(busy), 64'd0);
    check("t2_writes", 64'(n_wr - w0), 64'd2);
    check("t2_no_done", 64'(n_done - d0), 64'd0);

    // Erase never completes
    erase_hang = 1'b1;
    pulse_start(2'd0);
    check("t3_error_cleared", 64'(error), 64'd0);
    t = 0;
    while (!error && t < 400) begin
      @(negedge clock);
      t++;
    end
    check("t3_error", 64'(error), 64'd1);
    check("t3_latency", 64'(cyc - e_tog_cyc), 64'd102);
    check("t3_err_code", 64'(err_code), 64'(ERR_ERASE_TO));
    check("t3_busy", 64'(busy), 64'd0);
    erase_hang = 1'b0;
    tick(5);

    // Abort while the first page write is in flight
    w_hold = 1'b1;
    pulse_start(2'd0);
    send_page(rand_page());
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(6);
    check("t4_waits_for_flash", 64'(busy), 64'd1);
    w_hold = 1'b0;
    wait_idle();
    check("t4_error", 64'(error), 64'd1);
    check("t4_err_code", 64'(err_code), 64'(ERR_NONE));
    check("t4_page_count", 64'(page_count), 64'd0);
    tick(5);

    // Reset during a write, with the flash finishing afterwards
    w_hold = 1'b1;
    pulse_start(2'd1);
    send_page(rand_page());
    tick(3);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("t5_busy_after_rst", 64'(busy), 64'd0);
    check("t5_error_after_rst", 64'(error), 64'd0);
    w_hold = 1'b0;
    tick(20);
    check("t5_no_verify", 64'(page_count), 64'd0);
    check("t5_idle", 64'(busy), 64'd0);
    check("t5_no_ready", 64'(page_ready), 64'd0);

    // Fresh run; start and page_valid while not ready are both ignored
    e0 = n_erase; w0 = n_wr; d0 = n_done;
    held = fl_wr_data;
    pulse_start(2'd3);
    slot_sel = 2'd1;
    start = 1'b1;
    page_in = rand_page();
    page_valid = 1'b1;
    tick(1);
    start = 1'b0;
    page_valid = 1'b0;
    tick(2);
    check("t6_slot_kept", 64'(fl_slot_num), 64'd3);
    check("t6_wr_data_kept", 64'(fl_wr_data == held), 64'd1);
    for (int i = 0; i < NP; i++) send_page(rand_page());
    wait_idle();
    tick(10);
    check("t6_erases", 64'(n_erase - e0), 64'd1);
    check("t6_writes", 64'(n_wr - w0), 64'(NP));
    check("t6_page_count", 64'(page_count), 64'(NP));
    check("t6_done_pulses", 64'(n_done - d0), 64'd1);
    check("t6_error", 64'(error), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
